// File: rtl/dcp_pkg.sv
// rtl/dcp_pkg.sv - shared constants, state encoding and helpers for the command dispatcher
package dcp_pkg;

  localparam logic [7:0] ASCII_SP  = 8'h20;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_QM  = 8'h3F;
  localparam logic [7:0] ASCII_GT  = 8'h3E;
  localparam logic [7:0] CASE_FOLD = 8'h20;

  typedef enum logic [2:0] {
    S_PROMPT,
    S_WAIT_CMD,
    S_DECODE,
    S_LAUNCH,
    S_RUN,
    S_ERR_Q,
    S_ERR_CR,
    S_ERR_LF
  } state_t;

  function automatic logic [7:0] fold_case(input logic [7:0] b);
    return b | CASE_FOLD;
  endfunction

  function automatic logic is_blank(input logic [7:0] b);
    return (b == ASCII_SP) || (b == ASCII_CR) || (b == ASCII_LF);
  endfunction

endpackage

// File: rtl/dcp_dispatch_if.sv
// rtl/dcp_dispatch_if.sv - UART byte channels and processor-slot bundle of the dispatcher
interface dcp_dispatch_if #(
  parameter int NCMD = 4
);
  logic [7:0]         d_rx;
  logic               vld_rx;
  logic               rdy_rx;
  logic [7:0]         d_tx;
  logic               vld_tx;
  logic               rdy_tx;
  logic [NCMD-1:0]    sub_we;
  logic [NCMD-1:0]    sub_finish;
  logic [8*NCMD-1:0]  sub_d_tx;
  logic [NCMD-1:0]    sub_vld_tx;
  logic [NCMD-1:0]    sub_rdy_tx;
  logic [NCMD-1:0]    sub_vld_rx;
  logic [NCMD-1:0]    sub_rdy_rx;
  logic [32*NCMD-1:0] sub_end_addr;
  logic [32*NCMD-1:0] sub_last_addr;
  logic               busy;

  modport master (
    input  d_rx, vld_rx, rdy_tx, sub_finish, sub_d_tx, sub_vld_tx, sub_rdy_rx, sub_end_addr,
    output rdy_rx, d_tx, vld_tx, sub_we, sub_rdy_tx, sub_vld_rx, sub_last_addr, busy
  );

  modport slave (
    output d_rx, vld_rx, rdy_tx, sub_finish, sub_d_tx, sub_vld_tx, sub_rdy_rx, sub_end_addr,
    input  rdy_rx, d_tx, vld_tx, sub_we, sub_rdy_tx, sub_vld_rx, sub_last_addr, busy
  );
endinterface

// File: rtl/dcp_chan_mux.sv
// rtl/dcp_chan_mux.sv - grant-indexed mux/demux of the shared UART channels
module dcp_chan_mux #(
  parameter int NCMD = 4,
  parameter int GW   = 2
) (
  input  logic              route,
  input  logic [GW-1:0]     grant,
  input  logic              rdy_tx,
  input  logic              vld_rx,
  input  logic [8*NCMD-1:0] sub_d_tx,
  input  logic [NCMD-1:0]   sub_vld_tx,
  input  logic [NCMD-1:0]   sub_rdy_rx,
  output logic [7:0]        run_d_tx,
  output logic              run_vld_tx,
  output logic              run_rdy_rx,
  output logic [NCMD-1:0]   sub_rdy_tx,
  output logic [NCMD-1:0]   sub_vld_rx
);

  // Non-granted slots see all-zero handshakes so they can never move a byte.
  always_comb begin
    run_d_tx   = '0;
    run_vld_tx = 1'b0;
    run_rdy_rx = 1'b0;
    sub_rdy_tx = '0;
    sub_vld_rx = '0;
    if (route) begin
      run_d_tx          = sub_d_tx[grant*8 +: 8];
      run_vld_tx        = sub_vld_tx[grant];
      run_rdy_rx        = sub_rdy_rx[grant];
      sub_rdy_tx[grant] = rdy_tx;
      sub_vld_rx[grant] = vld_rx;
    end
  end

endmodule

// File: rtl/dcp_dispatch.sv
// rtl/dcp_dispatch.sv - prompt, command-letter decode and processor launch/grant FSM
module dcp_dispatch
  import dcp_pkg::*;
#(
  parameter int                NCMD      = 4,
  parameter logic [8*NCMD-1:0] CMD_CHARS = {"T", "B", "I", "D"},
  parameter logic [7:0]        PROMPT    = ASCII_GT
) (
  input logic            clk,
  input logic            rst,
  dcp_dispatch_if.master bus
);

  localparam int GW = (NCMD > 1) ? $clog2(NCMD) : 1;

  state_t             state;
  logic [GW-1:0]      grant;
  logic [7:0]         cmd;
  logic [7:0]         fsm_d_tx;
  logic               fsm_vld_tx;
  logic               fsm_rdy_rx;
  logic [NCMD-1:0]    we;
  logic [32*NCMD-1:0] last_addr;
  logic               hit;
  logic [GW-1:0]      hit_idx;
  logic               route;
  logic [7:0]         run_d_tx;
  logic               run_vld_tx;
  logic               run_rdy_rx;

  // Scan from the top so the lowest matching slot is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NCMD - 1; k >= 0; k--) begin
      if (fold_case(cmd) == fold_case(CMD_CHARS[8*k +: 8])) begin
        hit     = 1'b1;
        hit_idx = GW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_PROMPT;
      grant      <= '0;
      cmd        <= '0;
      fsm_d_tx   <= '0;
      fsm_vld_tx <= 1'b0;
      fsm_rdy_rx <= 1'b0;
      we         <= '0;
      last_addr  <= '0;
    end else begin
      we <= '0;
      case (state)
        S_PROMPT: begin
          // Only after reset is the prompt not already on the wire.
          if (!fsm_vld_tx) begin
            fsm_vld_tx <= 1'b1;
            fsm_d_tx   <= PROMPT;
          end else if (bus.rdy_tx) begin
            fsm_vld_tx <= 1'b0;
            fsm_d_tx   <= '0;
            fsm_rdy_rx <= 1'b1;
            state      <= S_WAIT_CMD;
          end
        end
        S_WAIT_CMD: begin
          if (bus.vld_rx && !is_blank(bus.d_rx)) begin
            cmd        <= bus.d_rx;
            fsm_rdy_rx <= 1'b0;
            state      <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (hit) begin
            grant       <= hit_idx;
            we[hit_idx] <= 1'b1;
            state       <= S_LAUNCH;
          end else begin
            fsm_vld_tx <= 1'b1;
            fsm_d_tx   <= ASCII_QM;
            state      <= S_ERR_Q;
          end
        end
        S_LAUNCH: state <= S_RUN;
        S_RUN: begin
          if (bus.sub_finish[grant]) begin
            last_addr[grant*32 +: 32] <= bus.sub_end_addr[grant*32 +: 32];
            fsm_vld_tx <= 1'b1;
            fsm_d_tx   <= PROMPT;
            state      <= S_PROMPT;
          end
        end
        S_ERR_Q: begin
          if (bus.rdy_tx) begin
            fsm_d_tx <= ASCII_CR;
            state    <= S_ERR_CR;
          end
        end
        S_ERR_CR: begin
          if (bus.rdy_tx) begin
            fsm_d_tx <= ASCII_LF;
            state    <= S_ERR_LF;
          end
        end
        S_ERR_LF: begin
          if (bus.rdy_tx) begin
            fsm_d_tx <= PROMPT;
            state    <= S_PROMPT;
          end
        end
        default: state <= S_PROMPT;
      endcase
    end
  end

  assign route = (state == S_RUN);

  dcp_chan_mux #(
    .NCMD (NCMD),
    .GW   (GW)
  ) u_chan_mux (
    .route      (route),
    .grant      (grant),
    .rdy_tx     (bus.rdy_tx),
    .vld_rx     (bus.vld_rx),
    .sub_d_tx   (bus.sub_d_tx),
    .sub_vld_tx (bus.sub_vld_tx),
    .sub_rdy_rx (bus.sub_rdy_rx),
    .run_d_tx   (run_d_tx),
    .run_vld_tx (run_vld_tx),
    .run_rdy_rx (run_rdy_rx),
    .sub_rdy_tx (bus.sub_rdy_tx),
    .sub_vld_rx (bus.sub_vld_rx)
  );

  assign bus.d_tx          = route ? run_d_tx   : fsm_d_tx;
  assign bus.vld_tx        = route ? run_vld_tx : fsm_vld_tx;
  assign bus.rdy_rx        = route ? run_rdy_rx : fsm_rdy_rx;
  assign bus.sub_we        = we;
  assign bus.sub_last_addr = last_addr;
  assign bus.busy          = (state != S_WAIT_CMD);

endmodule

// File: tb/tb_dcp_dispatch.sv
// tb/tb_dcp_dispatch.sv - directed self-checking bench for dcp_dispatch
module tb_dcp_dispatch;

  logic       clk;
  logic       rst;
  int         total = 0;
  int         bad = 0;
  logic       we_clr;
  logic [3:0] we_seen;

  dcp_dispatch_if #(.NCMD(4)) bus();

  dcp_dispatch #(
    .NCMD      (4),
    .CMD_CHARS ({"T", "B", "I", "D"}),
    .PROMPT    (8'h3E)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (we_clr) we_seen <= '0;
    else        we_seen <= we_seen | bus.sub_we;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench stuck");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic get_tx(output logic [7:0] b, output logic ok);
    ok = 1'b0;
    b  = '0;
    bus.rdy_tx = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (bus.vld_tx) begin
        b  = bus.d_tx;
        ok = 1'b1;
      end
      tick();
    end
    bus.rdy_tx = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, output logic ok);
    ok = 1'b0;
    bus.d_rx   = b;
    bus.vld_rx = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      ok = bus.rdy_rx;
      tick();
    end
    bus.vld_rx = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] b;
    logic       ok;
    rst = 1'b1;
    bus.rdy_tx = 1'b1;
    tick();
    tick();
    #1;
    total++; if (bus.vld_tx !== 1'b0) begin bad++; $display("FAIL rst_vld_tx got=%0h want=0", bus.vld_tx); end
    total++; if (bus.d_tx !== 8'h00) begin bad++; $display("FAIL rst_d_tx got=%0h want=00", bus.d_tx); end
    total++; if (bus.rdy_rx !== 1'b0) begin bad++; $display("FAIL rst_rdy_rx got=%0h want=0", bus.rdy_rx); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%0h want=1", bus.busy); end
    total++; if (bus.sub_we !== 4'h0) begin bad++; $display("FAIL rst_sub_we got=%0h want=0", bus.sub_we); end
    total++; if (bus.sub_rdy_tx !== 4'h0) begin bad++; $display("FAIL rst_sub_rdy_tx got=%0h want=0", bus.sub_rdy_tx); end
    total++; if (bus.sub_last_addr !== 128'h0) begin bad++; $display("FAIL rst_last_addr got=%0h want=0", bus.sub_last_addr); end
    tick();
    rst = 1'b0;
    bus.rdy_tx = 1'b0;
    get_tx(b, ok);
    total++; if (!ok || b !== 8'h3E) begin bad++; $display("FAIL first_prompt got=%0h ok=%0d want=3e", b, ok); end
    #1;
    total++; if (bus.rdy_rx !== 1'b1) begin bad++; $display("FAIL wait_rdy_rx got=%0h want=1", bus.rdy_rx); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL wait_busy got=%0h want=0", bus.busy); end
    total++; if (bus.vld_tx !== 1'b0) begin bad++; $display("FAIL wait_vld_tx got=%0h want=0", bus.vld_tx); end
    tick();
  endtask

  task automatic test_cmd_d;
    logic [7:0] b;
    logic       ok;
    send_rx(8'h64, ok);
    total++; if (!ok) begin bad++; $display("FAIL d_accept got=0 want=1"); end
    #1;
    total++; if (bus.sub_we !== 4'h0) begin bad++; $display("FAIL d_we_t1 got=%0h want=0", bus.sub_we); end
    tick(); #1;
    total++; if (bus.sub_we !== 4'b0001) begin bad++; $display("FAIL d_we_t2 got=%0h want=1", bus.sub_we); end
    tick(); #1;
    total++; if (bus.sub_we !== 4'h0) begin bad++; $display("FAIL d_we_t3 got=%0h want=0", bus.sub_we); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL d_busy got=%0h want=1", bus.busy); end
    tick();
    bus.sub_d_tx   = {8'h00, 8'h00, 8'h00, 8'h41};
    bus.sub_vld_tx = 4'b0001;
    bus.rdy_tx     = 1'b1;
    #1;
    total++; if (bus.d_tx !== 8'h41 || bus.vld_tx !== 1'b1) begin bad++; $display("FAIL d_route_tx got=%0h/%0h want=41/1", bus.d_tx, bus.vld_tx); end
    total++; if (bus.sub_rdy_tx !== 4'b0001) begin bad++; $display("FAIL d_sub_rdy_tx got=%0h want=1", bus.sub_rdy_tx); end
    tick();
    bus.sub_vld_tx = 4'h0;
    bus.rdy_tx     = 1'b0;
    bus.sub_end_addr[31:0] = 32'h0000_0010;
    bus.sub_finish = 4'b0001;
    tick();
    bus.sub_finish = 4'h0;
    #1;
    total++; if (bus.sub_last_addr[31:0] !== 32'h10) begin bad++; $display("FAIL d_last_addr got=%0h want=10", bus.sub_last_addr[31:0]); end
    total++; if (bus.vld_tx !== 1'b1 || bus.d_tx !== 8'h3E) begin bad++; $display("FAIL d_prompt_next got=%0h/%0h want=1/3e", bus.vld_tx, bus.d_tx); end
    tick();
    get_tx(b, ok);
    total++; if (!ok || b !== 8'h3E) begin bad++; $display("FAIL d_prompt got=%0h want=3e", b); end
  endtask

  task automatic test_bad_cmd;
    logic [7:0] b;
    logic       ok;
    logic [7:0] exp_b [4];
    exp_b = '{8'h3F, 8'h0D, 8'h0A, 8'h3E};
    we_clr = 1'b1;
    tick();
    we_clr = 1'b0;
    send_rx(8'h78, ok);
    total++; if (!ok) begin bad++; $display("FAIL x_accept got=0 want=1"); end
    for (int i = 0; i < 4; i++) begin
      get_tx(b, ok);
      total++; if (!ok || b !== exp_b[i]) begin bad++; $display("FAIL x_err_byte%0d got=%0h want=%0h", i, b, exp_b[i]); end
      tick();
    end
    total++; if (we_seen !== 4'h0) begin bad++; $display("FAIL x_no_we got=%0h want=0", we_seen); end
  endtask

  task automatic test_whitespace_hold;
    logic ok;
    send_rx(8'h20, ok);
    #1;
    total++; if (!ok || bus.busy !== 1'b0 || bus.rdy_rx !== 1'b1) begin bad++; $display("FAIL ws_sp got=%0d/%0h/%0h want=1/0/1", ok, bus.busy, bus.rdy_rx); end
    tick();
    send_rx(8'h0D, ok);
    #1;
    total++; if (!ok || bus.busy !== 1'b0 || bus.rdy_rx !== 1'b1) begin bad++; $display("FAIL ws_cr got=%0d/%0h/%0h want=1/0/1", ok, bus.busy, bus.rdy_rx); end
    tick();
    send_rx(8'h49, ok);
    #1;
    total++; if (!ok || bus.sub_we !== 4'h0) begin bad++; $display("FAIL i_we_t1 got=%0h want=0", bus.sub_we); end
    tick(); #1;
    total++; if (bus.sub_we !== 4'b0010) begin bad++; $display("FAIL i_we_t2 got=%0h want=2", bus.sub_we); end
    tick(); tick();
    bus.rdy_tx     = 1'b0;
    bus.sub_d_tx   = {8'h00, 8'h00, 8'h5A, 8'h00};
    bus.sub_vld_tx = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (bus.d_tx !== 8'h5A || bus.vld_tx !== 1'b1) begin bad++; $display("FAIL i_hold%0d got=%0h/%0h want=5a/1", i, bus.d_tx, bus.vld_tx); end
      tick();
    end
    bus.rdy_tx = 1'b1;
    #1;
    total++; if (bus.sub_rdy_tx !== 4'b0010) begin bad++; $display("FAIL i_sub_rdy_tx got=%0h want=2", bus.sub_rdy_tx); end
    tick();
    bus.sub_vld_tx = 4'h0;
    bus.rdy_tx     = 1'b0;
  endtask

  task automatic test_foreign_finish;
    bus.sub_end_addr[95:64] = 32'hDEAD_BEEF;
    bus.sub_finish = 4'b0100;
    tick();
    bus.sub_finish = 4'h0;
    bus.vld_rx     = 1'b1;
    bus.d_rx       = 8'h55;
    bus.sub_rdy_rx = 4'b0010;
    #1;
    total++; if (bus.busy !== 1'b1 || bus.vld_tx !== 1'b0) begin bad++; $display("FAIL ff_state got=%0h/%0h want=1/0", bus.busy, bus.vld_tx); end
    total++; if (bus.sub_last_addr[95:64] !== 32'h0) begin bad++; $display("FAIL ff_last2 got=%0h want=0", bus.sub_last_addr[95:64]); end
    total++; if (bus.sub_vld_rx !== 4'b0010 || bus.rdy_rx !== 1'b1) begin bad++; $display("FAIL ff_rx_route got=%0h/%0h want=2/1", bus.sub_vld_rx, bus.rdy_rx); end
    tick();
    bus.vld_rx     = 1'b0;
    bus.sub_rdy_rx = 4'h0;
  endtask

  task automatic test_reset_mid;
    logic [7:0] b;
    logic       ok;
    bus.sub_d_tx   = {8'h00, 8'h00, 8'h77, 8'h00};
    bus.sub_vld_tx = 4'b0010;
    bus.rdy_tx     = 1'b1;
    #1;
    total++; if (bus.d_tx !== 8'h77) begin bad++; $display("FAIL rm_pre got=%0h want=77", bus.d_tx); end
    tick();
    rst = 1'b1;
    tick(); #1;
    total++; if (bus.vld_tx !== 1'b0 || bus.d_tx !== 8'h00) begin bad++; $display("FAIL rm_tx got=%0h/%0h want=0/0", bus.vld_tx, bus.d_tx); end
    total++; if (bus.sub_rdy_tx !== 4'h0 || bus.sub_vld_rx !== 4'h0 || bus.rdy_rx !== 1'b0) begin bad++; $display("FAIL rm_route got=%0h/%0h/%0h want=0/0/0", bus.sub_rdy_tx, bus.sub_vld_rx, bus.rdy_rx); end
    total++; if (bus.busy !== 1'b1 || bus.sub_we !== 4'h0) begin bad++; $display("FAIL rm_busy_we got=%0h/%0h want=1/0", bus.busy, bus.sub_we); end
    total++; if (bus.sub_last_addr !== 128'h0) begin bad++; $display("FAIL rm_last_addr got=%0h want=0", bus.sub_last_addr); end
    tick();
    rst = 1'b0;
    bus.sub_vld_tx = 4'h0;
    bus.rdy_tx     = 1'b0;
    get_tx(b, ok);
    total++; if (!ok || b !== 8'h3E) begin bad++; $display("FAIL rm_prompt got=%0h want=3e", b); end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [7:0] b;
    logic       ok;
    send_rx(8'h54, ok);
    tick(); #1;
    total++; if (!ok || bus.sub_we !== 4'b1000) begin bad++; $display("FAIL t_we got=%0h want=8", bus.sub_we); end
    tick(); tick();
    bus.sub_end_addr[127:96] = 32'h0000_1234;
    bus.sub_finish = 4'b1000;
    tick();
    bus.sub_finish = 4'h0;
    #1;
    total++; if (bus.sub_last_addr[127:96] !== 32'h1234 || bus.sub_last_addr[31:0] !== 32'h0) begin bad++; $display("FAIL t_last got=%0h want=1234/0", bus.sub_last_addr); end
    tick();
    get_tx(b, ok);
    total++; if (!ok || b !== 8'h3E) begin bad++; $display("FAIL t_prompt got=%0h want=3e", b); end
    send_rx(8'h62, ok);
    tick(); #1;
    total++; if (!ok || bus.sub_we !== 4'b0100) begin bad++; $display("FAIL b_we got=%0h want=4", bus.sub_we); end
    tick();
  endtask

  initial begin
    rst            = 1'b1;
    we_clr         = 1'b1;
    bus.d_rx       = '0;
    bus.vld_rx     = 1'b0;
    bus.rdy_tx     = 1'b0;
    bus.sub_finish = '0;
    bus.sub_d_tx   = '0;
    bus.sub_vld_tx = '0;
    bus.sub_rdy_rx = '0;
    bus.sub_end_addr = '0;
    tick();
    we_clr = 1'b0;
    test_reset();
    test_cmd_d();
    test_bad_cmd();
    test_whitespace_hold();
    test_foreign_finish();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
